// File: rtl/addsub_chunked_seq.sv
// Multi-cycle add/subtract unit with SF/CF/OF/PF/ZF flags.
// Each RUN cycle adds one CHUNK-wide slice, LSB first, through a carry register.
module addsub_chunked_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             SF,
  output logic             CF,
  output logic             OF,
  output logic             PF,
  output logic             ZF
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, bx_q, acc_q;
  logic             carry_q, zero_q;
  logic             load, step, last;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] acc_nx;

  // Operands shift right each step so the active slice is always bits [CHUNK-1:0];
  // the partial result shifts in from the top and is complete after the last chunk.
  assign last   = (idx_q == IDX_W'(NCHUNK - 1));
  assign csum   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, bx_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  assign acc_nx = (acc_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the whole datapath is reset, not just control, because result and
  // flags must read zero after a reset, including one that aborts an op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      result  <= '0;
      SF      <= 1'b0;
      CF      <= 1'b0;
      OF      <= 1'b0;
      PF      <= 1'b0;
      ZF      <= 1'b0;
    end else if (load) begin
      idx_q   <= '0;
      a_q     <= A;
      bx_q    <= B ^ {WIDTH{op[0]}};
      carry_q <= op[1] ? cin : op[0];
      zero_q  <= 1'b1;
      acc_q   <= '0;
    end else if (step) begin
      idx_q   <= idx_q + 1'b1;
      a_q     <= a_q >> CHUNK;
      bx_q    <= bx_q >> CHUNK;
      carry_q <= csum[CHUNK];
      zero_q  <= zero_q & (csum[CHUNK-1:0] == '0);
      acc_q   <= acc_nx;
      if (last) begin
        // Top slice of the operands is still in [CHUNK-1:0] here.
        result <= acc_nx;
        SF     <= acc_nx[WIDTH-1];
        CF     <= csum[CHUNK];
        OF     <= (a_q[CHUNK-1] == bx_q[CHUNK-1]) && (acc_nx[WIDTH-1] != a_q[CHUNK-1]);
        PF     <= ~^acc_nx[7:0];
        ZF     <= zero_q & (csum[CHUNK-1:0] == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_chunked_seq.sv
// Bench for addsub_chunked_seq: a 64/16 and a 32/8 instance, directed spec cases
// plus random sweeps against an arithmetic reference model.
module tb_addsub_chunked_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  iv, ordy, ir, ov;
  logic [63:0] a_in, b_in;
  logic [1:0]  op_in;
  logic        cin_in;
  logic [31:0] r32;
  logic [1:0][63:0] rs;
  logic [1:0][4:0]  fl;   // {SF,CF,OF,PF,ZF}

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_chunked_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a_in), .B(b_in), .op(op_in), .cin(cin_in),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(rs[0]),
    .SF(fl[0][4]), .CF(fl[0][3]), .OF(fl[0][2]), .PF(fl[0][1]), .ZF(fl[0][0])
  );

  addsub_chunked_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a_in[31:0]), .B(b_in[31:0]), .op(op_in), .cin(cin_in),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(r32),
    .SF(fl[1][4]), .CF(fl[1][3]), .OF(fl[1][2]), .PF(fl[1][1]), .ZF(fl[1][0])
  );

  assign rs[1] = {32'h0, r32};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic at width w. Returns {flags, result}.
  function automatic logic [68:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic [1:0] o, input logic c);
    logic [65:0] ua, ub, us, one, brw, k;
    logic signed [65:0] sa, sb, ss, smax, smin;
    logic [63:0] mask, res;
    logic sf, cf, of, pf, zf;
    one  = 66'd1;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua   = {2'b0, a & mask};
    ub   = {2'b0, b & mask};
    sa   = signed'(ua);
    sb   = signed'(ub);
    if (ua[w-1]) sa = sa - signed'(one << w);
    if (ub[w-1]) sb = sb - signed'(one << w);
    smax = signed'((one << (w - 1)) - one);
    smin = -signed'(one << (w - 1));
    if (!o[0]) begin
      k   = o[1] ? {65'd0, c} : 66'd0;
      us  = ua + ub + k;
      res = us[63:0] & mask;
      cf  = us[w];
      ss  = sa + sb + signed'(k);
    end else begin
      brw = o[1] ? {65'd0, ~c} : 66'd0;
      us  = ua - ub - brw;
      res = us[63:0] & mask;
      cf  = (ua >= ub + brw);
      ss  = sa - sb - signed'(brw);
    end
    of = (ss > smax) || (ss < smin);
    sf = res[w-1];
    zf = (res == 64'd0);
    pf = ~^res[7:0];
    return {sf, cf, of, pf, zf, res};
  endfunction

  // One complete transaction on instance sel, with 'stall' cycles of out_ready=0 in DONE.
  task automatic run_op(input int sel, input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] o, input logic c, input int stall,
                        output logic [63:0] got_r, output logic [4:0] got_f);
    int w, cnt;
    logic [68:0] e;
    w = (sel == 0) ? 64 : 32;
    cnt = 0;
    while (!ir[sel] && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, ".in_ready"}, 64'(ir[sel]), 64'd1);
    a_in = a; b_in = b; op_in = o; cin_in = c; iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
    op_in = 2'($urandom); cin_in = 1'($urandom);
    cnt = 0;
    while (!ov[sel] && cnt < 40) begin
      @(posedge clk); #1; cnt++;
    end
    check({tag, ".latency"}, 64'(cnt), 64'd4);
    e = model(w, a, b, o, c);
    got_r = rs[sel];
    got_f = fl[sel];
    check({tag, ".result"}, got_r, e[63:0]);
    check({tag, ".flags"}, 64'(got_f), 64'(e[68:64]));
    for (int i = 0; i < stall; i++) begin
      iv[sel] = 1'b1;
      a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
      @(posedge clk); #1;
      check({tag, ".stall_valid"}, 64'(ov[sel]), 64'd1);
      check({tag, ".stall_ready"}, 64'(ir[sel]), 64'd0);
      check({tag, ".stall_result"}, rs[sel], got_r);
      check({tag, ".stall_flags"}, 64'(fl[sel]), 64'(got_f));
    end
    iv[sel] = 1'b0;
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    check({tag, ".release_valid"}, 64'(ov[sel]), 64'd0);
    check({tag, ".release_ready"}, 64'(ir[sel]), 64'd1);
    check({tag, ".hold_result"}, rs[sel], got_r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic [4:0]  f;
    logic        seen;
    logic [63:0] ra, rb;
    rst = 1'b1; iv = '0; ordy = '0;
    a_in = '0; b_in = '0; op_in = '0; cin_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d.in_ready", s), 64'(ir[s]), 64'd1);
      check($sformatf("reset%0d.out_valid", s), 64'(ov[s]), 64'd0);
      check($sformatf("reset%0d.result", s), rs[s], 64'd0);
      check($sformatf("reset%0d.flags", s), 64'(fl[s]), 64'd0);
    end

    // Directed cases on the 64/16 instance; flags are {SF,CF,OF,PF,ZF}.
    run_op(0, "t1_add_cross", 64'h0000_0000_FFFF_FFFF, 64'd1, 2'd0, 1'b1, 0, r, f);
    check("t1.res_const", r, 64'h0000_0001_0000_0000);
    check("t1.flags_const", 64'(f), 64'(5'b00010));
    run_op(0, "t2_sub_zero", 64'd5, 64'd5, 2'd1, 1'b0, 0, r, f);
    check("t2a.flags_const", 64'(f), 64'(5'b01011));
    run_op(0, "t2_sub_borrow", 64'd0, 64'd1, 2'd1, 1'b1, 0, r, f);
    check("t2b.res_const", r, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2b.flags_const", 64'(f), 64'(5'b10010));
    run_op(0, "t3_add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 1'b0, 0, r, f);
    check("t3a.res_const", r, 64'h8000_0000_0000_0000);
    check("t3a.sf_cf_of", 64'(f[4:2]), 64'(3'b101));
    run_op(0, "t3_sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 2'd1, 1'b0, 0, r, f);
    check("t3b.sf_of", 64'({f[4], f[2]}), 64'(2'b01));
    run_op(0, "t4_add_lo", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd0, 1'b0, 0, r, f);
    check("t4a.res_const", r, 64'd0);
    check("t4a.cf", 64'(f[3]), 64'd1);
    run_op(0, "t4_adc_hi", 64'd0, 64'd0, 2'd2, f[3], 0, r, f);
    check("t4b.res_const", r, 64'd1);
    run_op(0, "t4_sbb", 64'd0, 64'd0, 2'd3, 1'b0, 0, r, f);
    check("t4c.res_const", r, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t4c.cf", 64'(f[3]), 64'd0);
    run_op(0, "t5_stall", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'd1, 1'b0, 10, r, f);
    run_op(0, "t5_after", 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 2'd0, 1'b0, 0, r, f);

    // Abort with rst while the 64/16 instance is in RUN at idx=2.
    a_in = 64'h1111_2222_3333_4444; b_in = 64'h5555_6666_7777_8888;
    op_in = 2'd0; cin_in = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6.rst_result", rs[0], 64'd0);
    check("t6.rst_flags", 64'(fl[0]), 64'd0);
    check("t6.rst_valid", 64'(ov[0]), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | ov[0];
    end
    check("t6.no_valid_after_abort", 64'(seen), 64'd0);
    check("t6.ready_after_abort", 64'(ir[0]), 64'd1);

    // Random sweeps; a quarter of operands are biased to boundary values.
    for (int i = 0; i < 40; i++) begin
      ra = {32'h0, $urandom};
      rb = {32'h0, $urandom};
      if (($urandom % 4) == 0) ra = {32'h0, (($urandom % 2) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000};
      if (($urandom % 4) == 0) rb = {32'h0, (($urandom % 2) != 0) ? 32'hFFFF_FFFF : 32'h0};
      run_op(1, $sformatf("r32_%0d", i), ra, rb, 2'($urandom), 1'($urandom),
             int'($urandom % 3), r, f);
    end
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (($urandom % 4) == 0) rb = ~ra;
      run_op(0, $sformatf("r64_%0d", i), ra, rb, 2'($urandom), 1'($urandom),
             int'($urandom % 3), r, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
